// File: rtl/collision_pkg.sv
// collision_pkg: shared types and sizing helpers for the collision scheduler.
//   coll_state_t  - scheduler FSM states
//   DIST_W        - squared-distance width at the default coordinate width
//   DEF_THRESH    - default hit threshold (hit when d2 < THRESH)
//   dist_w/idx_w  - width helpers for parameterised instances
package collision_pkg;
    typedef enum logic [2:0] {IDLE, DIFF, SQ, CMP, DONE} coll_state_t;
    localparam int DEF_COORD_W = 9;
    localparam int DIST_W = 2 * DEF_COORD_W + 1;
    localparam int DEF_THRESH = 12;
    function automatic int dist_w(input int coord_w);
        return 2 * coord_w + 1;
    endfunction
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sq_dist_unit.sv
// sq_dist_unit: two-stage registered squared distance between points a and b.
//   clk, rst_n (async active-low)
//   diff_en : load |ax-bx|, |ay-by|
//   sq_en   : load d2 = dx*dx + dy*dy
//   ax, ay, bx, by : unsigned coordinates
//   d2      : registered squared distance, 2*COORD_W+1 bits (cannot overflow)
module sq_dist_unit #(
    parameter int COORD_W = 9,
    parameter int DIST_W = 2 * COORD_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               diff_en,
    input  logic               sq_en,
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    output logic [DIST_W-1:0]  d2
);
    logic [COORD_W-1:0] dx, dy;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx <= '0;
            dy <= '0;
            d2 <= '0;
        end else begin
            // subtract larger minus smaller so the magnitude never wraps
            if (diff_en) begin
                dx <= (ax > bx) ? ax - bx : bx - ax;
                dy <= (ay > by) ? ay - by : by - ay;
            end
            if (sq_en)
                d2 <= DIST_W'(dx) * DIST_W'(dx) + DIST_W'(dy) * DIST_W'(dy);
        end
    end
endmodule

// File: rtl/collision_scheduler.sv
// collision_scheduler: scans N_MON monsters through one shared squared-distance unit.
//   clk, rst_n (async active-low), start (sampled in IDLE only)
//   p_x, p_y      : pacman position
//   m_x, m_y      : monster positions, monster i at [i*COORD_W +: COORD_W]
//   busy          : scan in progress
//   done          : one-cycle pulse when hit_* are freshly loaded
//   hit_vec/any/idx : per-monster hits, OR of hits, lowest hit index
// Optional macro COLLISION_EARLY_EXIT_EN: stop the scan at the first hit.
module collision_scheduler
    import collision_pkg::*;
#(
    parameter int N_MON = 4,
    parameter int COORD_W = 9,
    parameter int THRESH = DEF_THRESH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [COORD_W-1:0]       p_x,
    input  logic [COORD_W-1:0]       p_y,
    input  logic [N_MON*COORD_W-1:0] m_x,
    input  logic [N_MON*COORD_W-1:0] m_y,
    output logic                     busy,
    output logic                     done,
    output logic [N_MON-1:0]         hit_vec,
    output logic                     hit_any,
    output logic [2:0]               hit_idx
);
    localparam int IW = idx_w(N_MON);
    localparam int DW = dist_w(COORD_W);
    coll_state_t state, state_nxt;
    logic [IW-1:0] idx;
    logic [COORD_W-1:0] sp_x, sp_y;
    logic [N_MON*COORD_W-1:0] sm_x, sm_y;
    logic [N_MON-1:0] scratch, scratch_nxt;
    logic [DW-1:0] d2;
    logic hit, fin;
    logic [2:0] lo;
    sq_dist_unit #(.COORD_W(COORD_W), .DIST_W(DW)) u_sq (
        .clk(clk),
        .rst_n(rst_n),
        .diff_en(state == DIFF),
        .sq_en(state == SQ),
        .ax(sp_x),
        .ay(sp_y),
        .bx(sm_x[int'(idx) * COORD_W +: COORD_W]),
        .by(sm_y[int'(idx) * COORD_W +: COORD_W]),
        .d2(d2)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        hit = 32'(d2) < THRESH;
        scratch_nxt = scratch | (N_MON'(hit) << idx);
`ifdef COLLISION_EARLY_EXIT_EN
        fin = (idx == IW'(N_MON - 1)) || hit;
`else
        fin = (idx == IW'(N_MON - 1));
`endif
        state_nxt = (state == IDLE) ? (start ? DIFF : IDLE) :
                    (state == DIFF) ? SQ :
                    (state == SQ)   ? CMP :
                    (state == CMP)  ? (fin ? DONE : DIFF) : IDLE;
        lo = '0;
        for (int i = N_MON - 1; i >= 0; i--)
            if (scratch_nxt[i]) lo = 3'(i);
        busy = state != IDLE;
        done = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            sp_x <= '0;
            sp_y <= '0;
            sm_x <= '0;
            sm_y <= '0;
            scratch <= '0;
            hit_vec <= '0;
            hit_any <= 1'b0;
            hit_idx <= '0;
        end else begin
            if (state == IDLE && start) begin
                sp_x <= p_x;
                sp_y <= p_y;
                sm_x <= m_x;
                sm_y <= m_y;
                scratch <= '0;
                idx <= '0;
            end
            if (state == CMP) begin
                scratch <= scratch_nxt;
                if (!fin) idx <= idx + 1'b1;
            end
            // results load on the DONE-entry edge, including the last monster's bit
            if (state == CMP && fin) begin
                hit_vec <= scratch_nxt;
                hit_any <= |scratch_nxt;
                hit_idx <= lo;
            end
        end
    end
endmodule
